// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: out1 = in1 + W*in2, out2 = in1 - W*in2, 3 stages with valid/ready.
// Optional FFT_BUTTERFLY_SCALE_EN adds scale_in for per-sample round-half-up divide by two.
module fft_butterfly_pipe #(
   parameter int IN_W    = 33,
   parameter int IN_FRAC = 14,
   parameter int TW_W    = 16,
   parameter int TW_FRAC = 14,
   parameter int TAG_W   = 8,
   localparam int OUT_W    = IN_W + TW_W + 1,
   localparam int OUT_FRAC = IN_FRAC + TW_FRAC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    inverse,
`ifdef FFT_BUTTERFLY_SCALE_EN
   input  logic                    scale_in,
`endif
   input  logic [TAG_W-1:0]        in_tag,
   input  logic signed [IN_W-1:0]  in1_real,
   input  logic signed [IN_W-1:0]  in1_imag,
   input  logic signed [IN_W-1:0]  in2_real,
   input  logic signed [IN_W-1:0]  in2_imag,
   input  logic signed [TW_W-1:0]  tw_real,
   input  logic signed [TW_W-1:0]  tw_imag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [TAG_W-1:0]        out_tag,
   output logic signed [OUT_W-1:0] out1_real,
   output logic signed [OUT_W-1:0] out1_imag,
   output logic signed [OUT_W-1:0] out2_real,
   output logic signed [OUT_W-1:0] out2_imag
);
   localparam int PW       = IN_W + TW_W;
   localparam int ALIGN_SH = OUT_FRAC - IN_FRAC;
   localparam logic signed [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

   logic                    w_en;
   logic                    r1_valid, r2_valid, r3_valid;
   logic                    r1_inv, r2_inv;
   logic [TAG_W-1:0]        r1_tag, r2_tag, r3_tag;
   logic signed [IN_W-1:0]  r1_in1_r, r1_in1_i, r1_in2_r, r1_in2_i;
   logic signed [TW_W-1:0]  r1_tw_r, r1_tw_i;
   logic signed [IN_W-1:0]  r2_in1_r, r2_in1_i;
   // product order: rr, ii, ri (in2_r*tw_i), ir (in2_i*tw_r)
   logic signed [PW-1:0]    r2_p [4];
   logic signed [OUT_W-1:0] r3_res [4];
`ifdef FFT_BUTTERFLY_SCALE_EN
   logic                    r1_scale, r2_scale;
`endif

   logic signed [OUT_W-1:0] w_px [4];
   logic signed [OUT_W-1:0] w_raw [4];
   logic signed [OUT_W-1:0] w_res [4];
   logic signed [OUT_W-1:0] w_a_r, w_a_i, w_t_r, w_t_i;

   // A bubble in the last stage or a consuming downstream lets every stage advance.
   assign w_en      = !r3_valid || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r3_valid;
   assign out_tag   = r3_tag;
   assign out1_real = r3_res[0];
   assign out1_imag = r3_res[1];
   assign out2_real = r3_res[2];
   assign out2_imag = r3_res[3];

   // in1 moved onto the product binary point with zero-filled low bits.
   assign w_a_r = {{(OUT_W-IN_W){r2_in1_r[IN_W-1]}}, r2_in1_r} << ALIGN_SH;
   assign w_a_i = {{(OUT_W-IN_W){r2_in1_i[IN_W-1]}}, r2_in1_i} << ALIGN_SH;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_prod_ext
         assign w_px[gi] = {{(OUT_W-PW){r2_p[gi][PW-1]}}, r2_p[gi]};
      end
   endgenerate

   // Inverse mode applies conj(W) by swapping product signs, never negating the twiddle.
   assign w_t_r = r2_inv ? (w_px[0] + w_px[1]) : (w_px[0] - w_px[1]);
   assign w_t_i = r2_inv ? (w_px[3] - w_px[2]) : (w_px[2] + w_px[3]);

   assign w_raw[0] = w_a_r + w_t_r;
   assign w_raw[1] = w_a_i + w_t_i;
   assign w_raw[2] = w_a_r - w_t_r;
   assign w_raw[3] = w_a_i - w_t_i;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
`ifdef FFT_BUTTERFLY_SCALE_EN
         logic signed [OUT_W-1:0] w_rnd;
         assign w_rnd     = (w_raw[gi] + ONE) >>> 1;
         assign w_res[gi] = r2_scale ? w_rnd : w_raw[gi];
`else
         assign w_res[gi] = w_raw[gi];
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r2_valid <= 1'b0;
         r3_valid <= 1'b0;
         r1_inv   <= 1'b0;
         r2_inv   <= 1'b0;
         r1_tag   <= '0;
         r2_tag   <= '0;
         r3_tag   <= '0;
         r1_in1_r <= '0;
         r1_in1_i <= '0;
         r1_in2_r <= '0;
         r1_in2_i <= '0;
         r1_tw_r  <= '0;
         r1_tw_i  <= '0;
         r2_in1_r <= '0;
         r2_in1_i <= '0;
         for (int k = 0; k < 4; k++) begin
            r2_p[k]   <= '0;
            r3_res[k] <= '0;
         end
`ifdef FFT_BUTTERFLY_SCALE_EN
         r1_scale <= 1'b0;
         r2_scale <= 1'b0;
`endif
      end else if (w_en) begin
         r1_valid <= in_valid;
         r1_inv   <= inverse;
         r1_tag   <= in_tag;
         r1_in1_r <= in1_real;
         r1_in1_i <= in1_imag;
         r1_in2_r <= in2_real;
         r1_in2_i <= in2_imag;
         r1_tw_r  <= tw_real;
         r1_tw_i  <= tw_imag;

         r2_valid <= r1_valid;
         r2_inv   <= r1_inv;
         r2_tag   <= r1_tag;
         r2_in1_r <= r1_in1_r;
         r2_in1_i <= r1_in1_i;
         r2_p[0]  <= PW'(r1_in2_r) * PW'(r1_tw_r);
         r2_p[1]  <= PW'(r1_in2_i) * PW'(r1_tw_i);
         r2_p[2]  <= PW'(r1_in2_r) * PW'(r1_tw_i);
         r2_p[3]  <= PW'(r1_in2_i) * PW'(r1_tw_r);

         r3_valid <= r2_valid;
         r3_tag   <= r2_tag;
         for (int k = 0; k < 4; k++) begin
            r3_res[k] <= w_res[k];
         end
`ifdef FFT_BUTTERFLY_SCALE_EN
         r1_scale <= scale_in;
         r2_scale <= r1_scale;
`endif
      end
   end

endmodule
